// File: rtl/modexp_serial_core.sv
// Bit-serial square-and-multiply modular exponentiator (cypher = message^exponent mod modulus)
// built on an interleaved (Blakley) modular multiplier that consumes one multiplier bit per clock.
module modexp_serial_core #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] message,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] cypher,
  output logic             done,
  output logic             busy
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Handshake: go is a level request taken only in S_IDLE; done stays high
  // until go drops, and a new request needs go low for at least one cycle.
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_REDUCE, S_SQR, S_MUL, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d, e_q, e_d, n_q, n_d;
  logic [WIDTH-1:0] r_q, r_d, b_q, b_d, p_q, p_d, a_q, a_d;
  logic [WIDTH-1:0] cypher_q, cypher_d;
  logic [IW-1:0]    cnt_q, cnt_d, i_q, i_d;
  logic             done_q, done_d, busy_q, busy_d;

  logic [WIDTH-1:0] x_op, p_next;
  logic [WIDTH:0]   n_ext, t1, t2;
  logic             last;

  // One Blakley step: P = 2P + a_k*X, folded back below N after each add.
  // X < N always holds, so one conditional subtract per add is enough.
  always_comb begin
    x_op = b_q;
    if (state_q == S_REDUCE) x_op = WIDTH'(1);
    else if (state_q == S_SQR) x_op = r_q;
    n_ext = {1'b0, n_q};
    t1 = {p_q, 1'b0};
    if (t1 >= n_ext) t1 = t1 - n_ext;
    t2 = t1 + (a_q[WIDTH-1] ? {1'b0, x_op} : '0);
    if (t2 >= n_ext) t2 = t2 - n_ext;
    p_next = t2[WIDTH-1:0];
    last = (cnt_q == IW'(WIDTH - 1));
  end

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    e_d      = e_q;
    n_d      = n_q;
    r_d      = r_q;
    b_d      = b_q;
    p_d      = p_q;
    a_d      = a_q;
    cnt_d    = cnt_q;
    i_d      = i_q;
    cypher_d = cypher_q;
    done_d   = done_q;
    busy_d   = busy_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          m_d     = message;
          e_d     = exponent;
          n_d     = modulus;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cypher_d = '0;
        if (n_q < WIDTH'(2)) begin
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          // Base is reduced as M*1 with M as the multiplier, so any M >= N works.
          r_d     = WIDTH'(1);
          i_d     = IW'(WIDTH - 1);
          a_d     = m_q;
          p_d     = '0;
          cnt_d   = '0;
          state_d = S_REDUCE;
        end
      end
      S_REDUCE, S_SQR, S_MUL: begin
        p_d   = p_next;
        a_d   = a_q << 1;
        cnt_d = cnt_q + IW'(1);
        if (last) begin
          p_d   = '0;
          cnt_d = '0;
          if (state_q == S_REDUCE) begin
            b_d     = p_next;
            a_d     = r_q;
            state_d = S_SQR;
          end else begin
            r_d = p_next;
            a_d = p_next;
            if (state_q == S_SQR && e_q[i_q]) begin
              state_d = S_MUL;
            end else if (i_q == '0) begin
              cypher_d = p_next;
              done_d   = 1'b1;
              busy_d   = 1'b0;
              state_d  = S_DONE;
            end else begin
              i_d     = i_q - IW'(1);
              state_d = S_SQR;
            end
          end
        end
      end
      S_DONE: begin
        // The N<2 shortcut arrives with done still low; raise it before honouring go.
        if (!done_q) begin
          done_d = 1'b1;
        end else if (!go) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      m_q      <= '0;
      e_q      <= '0;
      n_q      <= '0;
      r_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      a_q      <= '0;
      cnt_q    <= '0;
      i_q      <= '0;
      cypher_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      e_q      <= e_d;
      n_q      <= n_d;
      r_q      <= r_d;
      b_q      <= b_d;
      p_q      <= p_d;
      a_q      <= a_d;
      cnt_q    <= cnt_d;
      i_q      <= i_d;
      cypher_q <= cypher_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign cypher = cypher_q;
  assign done   = done_q;
  assign busy   = busy_q;
endmodule
